// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates IMem/DMem waits, redirects and load-use
// hazards into per-stage stall/flush controls, with a sticky DMem timeout trap.
module pipe_ctrl #(
  parameter int NSTAGES   = 5,
  parameter int EX_STAGE  = 2,
  parameter int MEM_STAGE = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic               dmem_valid,
  output logic               dmem_req,
  input  logic               dmem_ack,
  input  logic               redirect,
  input  logic               ex_is_load,
  input  logic [4:0]         ex_rd_addr,
  input  logic [4:0]         id_rs1_addr,
  input  logic [4:0]         id_rs2_addr,
  output logic [NSTAGES-1:0] stall,
  output logic [NSTAGES-1:0] flush,
  output logic               timeout_err,
  output logic [31:0]        stall_cycles
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  // Stage masks; MEM_NEXT truncates to zero when MEM_STAGE is the last stage.
  localparam logic [NSTAGES-1:0] MEM_MASK  = NSTAGES'((64'd1 << (MEM_STAGE + 1)) - 64'd1);
  localparam logic [NSTAGES-1:0] MEM_NEXT  = NSTAGES'(64'd1 << (MEM_STAGE + 1));
  localparam logic [NSTAGES-1:0] PRE_EX    = NSTAGES'((64'd1 << EX_STAGE) - 64'd1);
  localparam logic [NSTAGES-1:0] EX_BIT    = NSTAGES'(64'd1 << EX_STAGE);
  localparam logic [NSTAGES-1:0] FETCH_BIT = NSTAGES'(64'd1);
  localparam logic [NSTAGES-1:0] DEC_BIT   = NSTAGES'(64'd2);

  typedef enum logic {I_REQ, I_WAIT} istate_t;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_ERR} dstate_t;

  istate_t          istate;
  dstate_t          dstate;
  logic             kill;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic [31:0]      stall_cnt;

  logic d_err;
  logic d_stall;
  logic load_use;
  logic i_hold;

  assign imem_req = reset;
  assign dmem_req = reset && ((dstate == D_WAIT) || ((dstate == D_IDLE) && dmem_valid));

  assign d_err    = (dstate == D_ERR);
  assign d_stall  = dmem_req && !dmem_ack;
  assign load_use = ex_is_load && (ex_rd_addr != 5'd0) &&
                    ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));
  // A killed fetch's returning word is treated like a wait: hold PC, bubble decode.
  assign i_hold   = imem_req && (!imem_ack || kill);
  assign wait_nxt = wait_cnt + CNT_W'(1);

  assign timeout_err  = d_err;
  assign stall_cycles = stall_cnt;

  always_comb begin
    stall = '0;
    flush = '0;
    if (!reset) begin
      flush = '1;
    end else if (d_err) begin
      stall = '1;
    end else if (d_stall) begin
      stall = MEM_MASK;
      flush = MEM_NEXT;
    end else if (redirect) begin
      flush = PRE_EX;
    end else if (load_use) begin
      stall = PRE_EX;
      flush = EX_BIT;
    end else if (i_hold) begin
      stall = FETCH_BIT;
      flush = DEC_BIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      istate <= I_REQ;
      kill   <= 1'b0;
    end else begin
      istate <= imem_ack ? I_REQ : I_WAIT;
      // Only a redirect that actually took effect poisons the outstanding fetch.
      if (imem_ack)
        kill <= 1'b0;
      else if ((istate == I_WAIT) && redirect && !d_stall && !d_err)
        kill <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dstate   <= D_IDLE;
      wait_cnt <= '0;
    end else begin
      case (dstate)
        D_IDLE: begin
          if (dmem_valid && !dmem_ack) begin
            dstate   <= D_WAIT;
            wait_cnt <= '0;
          end
        end
        D_WAIT: begin
          if (dmem_ack) begin
            dstate <= D_IDLE;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == CNT_W'(TIMEOUT))
              dstate <= D_ERR;
          end
        end
        D_ERR:   dstate <= D_ERR;
        default: dstate <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (stall[0] && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;
  localparam int NS  = 5;
  localparam int EX  = 2;
  localparam int MEM = 3;
  localparam int TO  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req, imem_ack;
  logic          dmem_valid, dmem_req, dmem_ack;
  logic          redirect, ex_is_load;
  logic [4:0]    ex_rd_addr, id_rs1_addr, id_rs2_addr;
  logic [NS-1:0] stall, flush;
  logic          timeout_err;
  logic [31:0]   stall_cycles;

  pipe_ctrl #(.NSTAGES(NS), .EX_STAGE(EX), .MEM_STAGE(MEM), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_valid(dmem_valid), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .redirect(redirect), .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .stall(stall),
    .flush(flush), .timeout_err(timeout_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit     m_pending;   // a fetch is outstanding from an earlier cycle
  bit     m_kill;
  bit     m_busy;      // a DMem access is waiting
  bit     m_err;
  int     m_waited;
  longint m_stalls;
  bit     cur_ds, cur_stall0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_kill = 0; m_busy = 0; m_err = 0; m_waited = 0; m_stalls = 0;
  endtask

  // Called at posedge+1 with inputs applied; checks at the following negedge.
  task automatic settle();
    logic [NS-1:0] es, ef;
    bit dreq, lu, ih;
    #4;
    if (!reset) model_reset();
    dreq = reset && !m_err && (m_busy || dmem_valid);
    cur_ds = dreq && !dmem_ack;
    lu = ex_is_load && (ex_rd_addr != 0) &&
         (ex_rd_addr == id_rs1_addr || ex_rd_addr == id_rs2_addr);
    ih = reset && (!imem_ack || m_kill);
    es = '0; ef = '0;
    if (!reset) ef = '1;
    else if (m_err) es = '1;
    else if (cur_ds) begin
      for (int i = 0; i < NS; i++) begin es[i] = (i <= MEM); ef[i] = (i == MEM + 1); end
    end else if (redirect) begin
      for (int i = 0; i < NS; i++) ef[i] = (i < EX);
    end else if (lu) begin
      for (int i = 0; i < NS; i++) begin es[i] = (i < EX); ef[i] = (i == EX); end
    end else if (ih) begin
      es[0] = 1'b1; ef[1] = 1'b1;
    end
    cur_stall0 = es[0];
    chk("stall", 64'(stall), 64'(es));
    chk("flush", 64'(flush), 64'(ef));
    chk("imem_req", 64'(imem_req), 64'(reset));
    chk("dmem_req", 64'(dmem_req), 64'(dreq));
    chk("timeout_err", 64'(timeout_err), 64'(m_err));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
    chk("exclusive", 64'(stall & flush), 64'd0);
  endtask

  task automatic advance();
    if (reset) begin
      if (cur_stall0 && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (imem_ack) m_kill = 0;
      else if (m_pending && redirect && !cur_ds && !m_err) m_kill = 1;
      m_pending = !imem_ack;
      if (!m_err) begin
        if (m_busy) begin
          if (dmem_ack) m_busy = 0;
          else begin
            m_waited++;
            if (m_waited >= TO) begin m_err = 1; m_busy = 0; end
          end
        end else if (dmem_valid && !dmem_ack) begin
          m_busy = 1; m_waited = 0;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    imem_ack = 1; dmem_valid = 0; dmem_ack = 0; redirect = 0; ex_is_load = 0;
    ex_rd_addr = 0; id_rs1_addr = 0; id_rs2_addr = 0;
  endtask

  initial begin
    int err_age;
    reset = 0;
    quiet();
    model_reset();
    @(posedge clk); #1;

    // Reset state
    settle();
    chk("rst_flush", 64'(flush), 64'h1F);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_ireq", 64'(imem_req), 64'h0);
    advance();
    reset = 1;

    // No hazards
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("idle_stall", 64'(stall), 64'h0);
      chk("idle_flush", 64'(flush), 64'h0);
      advance();
    end

    // DMem access acked after three wait cycles
    dmem_valid = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("dwait_stall", 64'(stall), 64'h0F);
      chk("dwait_flush", 64'(flush), 64'h10);
      advance();
    end
    dmem_ack = 1;
    settle();
    chk("dack_stall", 64'(stall), 64'h0);
    chk("dack_count", 64'(stall_cycles), 64'd3);
    advance();
    quiet();

    // Load-use hazard, then the x0 exemption
    ex_is_load = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_rs1_addr = 1;
    settle();
    chk("lu_stall", 64'(stall), 64'h03);
    chk("lu_flush", 64'(flush), 64'h04);
    advance();
    ex_rd_addr = 0; id_rs2_addr = 0;
    settle();
    chk("lu_x0_stall", 64'(stall), 64'h0);
    advance();
    quiet();

    // Redirect while a fetch is outstanding: the returning word is killed
    imem_ack = 0;
    settle(); chk("iwait_stall", 64'(stall), 64'h01); chk("iwait_flush", 64'(flush), 64'h02); advance();
    redirect = 1;
    settle(); chk("redir_flush", 64'(flush), 64'h03); chk("redir_stall", 64'(stall), 64'h0); advance();
    redirect = 0;
    settle(); chk("kwait_flush", 64'(flush), 64'h02); advance();
    imem_ack = 1;
    settle(); chk("kill_stall", 64'(stall), 64'h01); chk("kill_flush", 64'(flush), 64'h02); advance();
    settle(); chk("post_kill", 64'(flush), 64'h0); advance();

    // Redirect under DMem stall is suppressed, re-presented after the ack
    dmem_valid = 1; redirect = 1;
    settle(); chk("dr_stall", 64'(stall), 64'h0F); chk("dr_flush", 64'(flush), 64'h10); advance();
    dmem_ack = 1;
    settle(); chk("dr_redir", 64'(flush), 64'h03); chk("dr_nostall", 64'(stall), 64'h0); advance();
    quiet();

    // DMem timeout
    dmem_valid = 1;
    for (int i = 0; i < 5; i++) begin settle(); advance(); end
    settle();
    chk("to_err", 64'(timeout_err), 64'h1);
    chk("to_stall", 64'(stall), 64'h1F);
    chk("to_flush", 64'(flush), 64'h0);
    chk("to_dreq", 64'(dmem_req), 64'h0);
    advance();
    reset = 0;
    settle();
    chk("to_clear", 64'(timeout_err), 64'h0);
    chk("to_clear_cnt", 64'(stall_cycles), 64'h0);
    advance();
    reset = 1;
    quiet();

    // Randomized traffic
    err_age = 0;
    for (int c = 0; c < 4000; c++) begin
      err_age = m_err ? err_age + 1 : 0;
      reset       = !(($urandom_range(0, 59) == 0) || (err_age > 3));
      imem_ack    = ($urandom_range(0, 9) < 7);
      dmem_valid  = ($urandom_range(0, 9) < 3);
      dmem_ack    = ($urandom_range(0, 9) < 4);
      redirect    = ($urandom_range(0, 9) < 2);
      ex_is_load  = ($urandom_range(0, 9) < 3);
      ex_rd_addr  = 5'($urandom_range(0, 3));
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
